fsm_light_dimmer: RTL
=====================

Name: fsm_light_dimmer

Overview:
Parametrised successor to the on/off light FSM. A multi-bit switch code selects one of 2^SW_W brightness levels, and the block drives the light with a PWM output. Switch input is synchronised and debounced; brightness ramps linearly between levels, with an instant-change mode bypass. Sits between board switches and the LED pins.

Parameters:
SW_W, 2, switch code width; levels 0..2^SW_W-1 (level 0 = off)
PWM_W, 8, duty/PWM counter width; constraint PWM_W >= SW_W
DEB_CYCLES, 1000, consecutive stable cycles required to accept a switch code (>=1)
RAMP_CYCLES, 256, clock cycles per 1-LSB duty step while ramping (>=1)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_OnOffSW  in  SW_W  raw switch code (asynchronous, may bounce)
i_instant  in  1  1 = jump duty straight to target; 0 = ramp
o_light  out  1  PWM light drive
o_level  out  SW_W  debounced accepted level
o_duty  out  PWM_W  current duty value
o_busy  out  1  1 while duty != target

Behaviour:
- Reset (i_reset_n low, async): o_light=0, o_level=0, o_duty=0, o_busy=0, state S_HOLD, sync flops, debounce counter, prescaler and PWM counter all 0. Reset mid-ramp aborts the ramp immediately.
- Sync: i_OnOffSW passes through 2 flops (sw_s).
- Debounce: candidate register plus counter.
  - If sw_s != candidate: candidate<=sw_s, count<=0.
  - Else if candidate != o_level: count increments; when count reaches DEB_CYCLES-1, o_level<=candidate on that edge.
  - A code held stable appears on o_level DEB_CYCLES+2 edges after its first sampling. Any glitch shorter than that restarts the count.
- Target mapping, combinational from o_level:
  - level == 2^SW_W-1 -> target = all-ones.
  - Otherwise target = level << (PWM_W-SW_W).
- FSM states S_HOLD, S_RAMP_UP, S_RAMP_DOWN; evaluated every cycle:
  - i_instant=1 in any state: o_duty<=target; next state S_HOLD; prescaler<=0.
  - S_HOLD:
    - target>o_duty -> S_RAMP_UP, prescaler<=0.
    - target<o_duty -> S_RAMP_DOWN, prescaler<=0.
    - Otherwise stay.
  - S_RAMP_UP/S_RAMP_DOWN: prescaler counts 0..RAMP_CYCLES-1 and wraps. On prescaler==RAMP_CYCLES-1, o_duty steps ±1.
    - When the stepped value equals target -> S_HOLD.
    - If target changes mid-ramp, direction is re-evaluated every cycle: target now on the other side -> switch state, prescaler<=0; target == o_duty -> S_HOLD.
  - The first step occurs RAMP_CYCLES edges after entering a ramp state.
- o_busy = (state != S_HOLD), registered with state.
- PWM:
  - Counter runs 0..2^PWM_W-2, giving a period of 2^PWM_W-1 cycles.
  - o_light registered = (cnt < o_duty).
  - duty 0 -> constant 0; duty all-ones -> constant 1; no glitch pulses.
  - o_duty updates take effect on the next counter compare (no period alignment).
- No arithmetic overflow: duty never steps past 0 or all-ones because the step is bounded by target.

Decomposition:
- Package fsm_light_pkg: state encoding constants S_HOLD=2'd0, S_RAMP_UP=2'd1, S_RAMP_DOWN=2'd2, plus the level-to-duty mapping function.
- One sub-module sw_debounce (parameters SW_W, DEB_CYCLES; ports i_clk, i_reset_n, i_sw, o_sw) containing the sync and debounce logic.
- The FSM, prescaler and PWM stay in the top module.

Test Plan (SW_W=2, PWM_W=4, DEB_CYCLES=4, RAMP_CYCLES=2):
- Reset, then hold i_OnOffSW=2'b01 → o_level=1 exactly 6 edges after first sample; o_busy rises; o_duty steps 0→4, one step per 2 cycles; o_busy falls at 4; o_light high 4 of every 15 cycles.
- Bounce: 01,00,01,00 each held 2 cycles, then 00 stable → o_level never leaves 0; o_duty stays 0.
- Level 3 with i_instant=1 → o_duty=15 one edge after o_level=3; o_light constant 1; o_busy stays 0.
- Mid-ramp reversal: ramping 0→8 (level 2); at duty=3 switch to level 0 → state S_RAMP_DOWN; duty 3→2→1→0; S_HOLD; o_light constant 0.
- Assert i_reset_n low mid-ramp at duty=5 → all outputs 0 asynchronously (before the next edge). After release with the switch held at 01, the ramp restarts from 0.
- Level 3 ramp → duty reaches 15 and holds; no wrap to 0; o_light constant 1 over 3 full PWM periods.

Source files
------------

// File: rtl/fsm_light_pkg.sv
// Shared state encoding and level-to-duty mapping for the PWM light dimmer.
package fsm_light_pkg;

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RAMP_DOWN = 2'd2
  } state_e;

  // Top level saturates to full-on; other levels are the code scaled into the duty range.
  function automatic logic [31:0] level_to_duty(input logic [31:0] level,
                                                input int unsigned sw_w,
                                                input int unsigned pwm_w);
    logic [31:0] top_level;
    top_level = (32'd1 << sw_w) - 32'd1;
    if (level == top_level) begin
      return (32'd1 << pwm_w) - 32'd1;
    end
    return level << (pwm_w - sw_w);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stable-count debounce for a multi-bit switch code.
module sw_debounce #(
  parameter int unsigned SW_W       = 2,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_sw
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [SW_W-1:0]  r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [SW_W-1:0]  r_level;

  assign o_sw = r_level;

  // Any change of the synchronised code restarts the stability count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_level <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cand != r_level) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_level <= r_cand;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fsm_light_dimmer.sv
// Switch-selected brightness with linear duty ramping (or instant jump) and PWM drive.
module fsm_light_dimmer
  import fsm_light_pkg::*;
#(
  parameter int unsigned SW_W        = 2,
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned DEB_CYCLES  = 1000,
  parameter int unsigned RAMP_CYCLES = 256
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [SW_W-1:0]  i_OnOffSW,
  input  logic             i_instant,
  output logic             o_light,
  output logic [SW_W-1:0]  o_level,
  output logic [PWM_W-1:0] o_duty,
  output logic             o_busy
);

  localparam int unsigned PRESC_W  = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int unsigned PWM_LAST = (32'd1 << PWM_W) - 32'd2;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [PWM_W-1:0]   r_duty;
  logic [PWM_W-1:0]   w_duty_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic               r_busy;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic               r_light;
  logic [SW_W-1:0]    w_level;
  logic [PWM_W-1:0]   w_target;
  logic [PWM_W-1:0]   w_duty_up;
  logic [PWM_W-1:0]   w_duty_dn;
  logic               w_presc_wrap;

  sw_debounce #(
    .SW_W       (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sw      (i_OnOffSW),
    .o_sw      (w_level)
  );

  assign w_target     = PWM_W'(level_to_duty(32'(w_level), SW_W, PWM_W));
  assign w_duty_up    = r_duty + PWM_W'(1);
  assign w_duty_dn    = r_duty - PWM_W'(1);
  assign w_presc_wrap = (r_presc == PRESC_W'(RAMP_CYCLES - 1));

  assign o_level = w_level;
  assign o_duty  = r_duty;
  assign o_busy  = r_busy;
  assign o_light = r_light;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_HOLD;
      r_duty  <= '0;
      r_presc <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_presc <= w_presc_nxt;
      r_busy  <= (w_state_nxt != S_HOLD);
    end
  end

  // Direction is re-checked every cycle so a target change mid-ramp turns or stops it.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_presc_nxt = r_presc;
    if (i_instant) begin
      w_duty_nxt  = w_target;
      w_state_nxt = S_HOLD;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (w_target > r_duty) begin
            w_state_nxt = S_RAMP_UP;
            w_presc_nxt = '0;
          end else if (w_target < r_duty) begin
            w_state_nxt = S_RAMP_DOWN;
            w_presc_nxt = '0;
          end
        end
        S_RAMP_UP: begin
          if (w_target < r_duty) begin
            w_state_nxt = S_RAMP_DOWN;
            w_presc_nxt = '0;
          end else if (w_target == r_duty) begin
            w_state_nxt = S_HOLD;
          end else if (w_presc_wrap) begin
            w_presc_nxt = '0;
            w_duty_nxt  = w_duty_up;
            if (w_duty_up == w_target) w_state_nxt = S_HOLD;
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end
        S_RAMP_DOWN: begin
          if (w_target > r_duty) begin
            w_state_nxt = S_RAMP_UP;
            w_presc_nxt = '0;
          end else if (w_target == r_duty) begin
            w_state_nxt = S_HOLD;
          end else if (w_presc_wrap) begin
            w_presc_nxt = '0;
            w_duty_nxt  = w_duty_dn;
            if (w_duty_dn == w_target) w_state_nxt = S_HOLD;
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  // Period of 2^PWM_W-1 lets duty 0 and all-ones map to solid off and solid on.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pwm_cnt <= '0;
      r_light   <= 1'b0;
    end else begin
      r_light <= (r_pwm_cnt < r_duty);
      if (r_pwm_cnt == PWM_W'(PWM_LAST)) begin
        r_pwm_cnt <= '0;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end
    end
  end

endmodule
